multi_warp_scalar_reg_file: RTL and testbench
=============================================

// Module: multi_warp_scalar_reg_file
// PURPOSE
//  Parametrised scalar register file holding NUM_WARPS independent register sets.
//  Sits between the scheduler's REQUEST/UPDATE stages and the scalar ALU/LSU.
//  Provides registered 2-operand reads, a priority execute-stage write port and a
//  backpressured LSU writeback port. A per-register pending-write scoreboard lets issue logic stall on RAW hazards.
// PARAMETERS
//  DATA_WIDTH  `DATA_WIDTH  register width in bits
//  NUM_REGS    32           registers per warp (power of 2, >=4); last index = execution mask
//  NUM_WARPS   4            register sets (power of 2, >=1)
//  Derived: RA_W=$clog2(NUM_REGS), WID_W=max(1,$clog2(NUM_WARPS))
// PORTS
//  clk                    in   1             clock
//  reset                  in   1             asynchronous, active-high reset
//  rd_req_valid           in   1             operand read request (REQUEST stage)
//  rd_warp_id             in   WID_W         warp of read
//  rs1_addr / rs2_addr    in   RA_W          source indices
//  rd_rsp_valid           out  1             rs1/rs2/busy valid this cycle
//  rs1_data / rs2_data    out  DATA_WIDTH    operand data
//  rs1_busy / rs2_busy    out  1             source had pending LSU write at sample time
//  wr_valid               in   1             execute-stage write (UPDATE stage)
//  wr_warp_id             in   WID_W         warp of write
//  wr_addr                in   RA_W          destination index
//  wr_mux                 in   reg_input_mux_t  ALU_OUT/LSU_OUT/IMMEDIATE/PC_PLUS_1/VECTOR_TO_SCALAR
//  alu_out, lsu_out, immediate, vector_to_scalar_data  in  DATA_WIDTH  write sources
//  pc                     in   instruction_memory_address_t  PC for PC_PLUS_1
//  sb_set_valid           in   1             mark (sb_set_warp, sb_set_addr) pending
//  sb_set_warp / sb_set_addr  in  WID_W / RA_W
//  lsu_wb_valid / lsu_wb_ready  in / out  1  LSU writeback handshake
//  lsu_wb_warp / lsu_wb_addr / lsu_wb_data  in  WID_W / RA_W / DATA_WIDTH
//  warp_execution_mask    out  NUM_WARPS*DATA_WIDTH  reg[NUM_REGS-1] of each warp, warp 0 in LSBs
// BEHAVIOUR
//  - Reset (async): every warp r0=0, r1=all ones, r2..r(N-2)=0, r(N-1)=all ones; scoreboard clear;
//    rd_rsp_valid=0, rs*_data=0, rs*_busy=0. Reset mid-transaction drops in-flight writes; pending cleared.
//  - Read: rd_req_valid sampled at edge k -> data/busy on outputs and rd_rsp_valid=1 in cycle k+1;
//    outputs hold last value when no request; rd_rsp_valid is a 1-cycle pulse per request. Back-to-back reads every cycle.
//  - Read of r0 always returns 0, busy=0. Read same cycle as write to same reg returns OLD value (no macro).
//  - wr_valid: registers selected source into [wr_warp_id][wr_addr] at edge; PC_PLUS_1 = pc+1 zero-extended/truncated
//    to DATA_WIDTH; writes to addr 0 ignored; invalid wr_mux -> no write + $error (sim only).
//  - LSU port: lsu_wb_ready = !wr_valid (combinational); transfer when valid&&ready; data held by LSU until accepted.
//    Accepted transfer writes lsu_wb_data and clears pending bit for that (warp,addr). Addr 0: bit cleared, no write.
//  - Simultaneous wr and LSU transfer impossible (ready low). sb_set and LSU clear on same bit same edge: set wins.
//  - sb_set on addr 0 ignored. Execute write does not touch scoreboard.
//  - warp_execution_mask reflects register contents combinationally after the write edge.
//  - Warps fully isolated: no write to warp A alters any register/bit of warp B.
// CONFIGURATION
//  SCALAR_RF_BYPASS_EN defined: read request in same cycle as an accepted write (exec or LSU) to same
//   warp/addr (addr!=0) returns the NEW value; LSU bypass also reports busy=0 for that source.
//  Undefined: old value and pre-write busy returned; issue logic must space dependent ops by one cycle.
// STRUCTURE
//  Shared package (common): reg_input_mux_t (existing), warp_id_t, reg_addr_t, localparams ZERO_REG=0,
//   ONES_REG=1, EXEC_MASK_REG=NUM_REGS-1.
//  Sub-module scalar_scoreboard: NUM_WARPS x NUM_REGS pending bits, set/clear ports, two lookup ports, async reset.
//  Top: storage array, write mux, LSU handshake, read pipeline register, optional bypass.
// TESTING
//  1 Reset: read w0..w3 r0,r1,r5,r31 -> 0, FFFF_FFFF, 0, FFFF_FFFF; mask bus all ones; rd_rsp_valid=0.
//  2 wr ALU_OUT=0x1234 w2 r7, read w2 r7 next cycle -> rsp cycle after = 0x1234; read w1 r7 -> 0.
//  3 wr IMMEDIATE to r0 =0xDEAD, PC_PLUS_1 pc=0x10 to r3 -> r0 reads 0, r3 reads 0x11.
//  4 sb_set w1 r9; read -> busy=1; lsu_wb_valid with wr_valid high -> ready=0 hold 2 cycles; drop wr_valid ->
//    accepted, r9=0xCAFE, busy=0; same-edge set+clear w1 r9 -> busy stays 1.
//  5 Same-cycle wr w0 r4=0x55 (old 0) and read r4 -> 0 without macro, 0x55 with SCALAR_RF_BYPASS_EN.
//  6 Write w3 r31=0x0000_000F -> mask bits [127:96]=0xF, others unchanged; assert reset mid-LSU stall ->
//    all reset values, scoreboard clear, rd_rsp_valid=0 immediately.

Source files
------------

// File: rtl/multi_warp_scalar_reg_file_pkg.sv
// Shared types and constants for the multi-warp scalar register file.
// DATA_WIDTH defaults to 32 when the build does not define it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package multi_warp_scalar_reg_file_pkg;

    localparam int DEF_NUM_REGS  = 32;
    localparam int DEF_NUM_WARPS = 4;
    localparam int DEF_RA_W      = $clog2(DEF_NUM_REGS);
    localparam int DEF_WID_W     = (DEF_NUM_WARPS > 1) ? $clog2(DEF_NUM_WARPS) : 1;

    localparam int ZERO_REG      = 0;
    localparam int ONES_REG      = 1;
    localparam int EXEC_MASK_REG = DEF_NUM_REGS - 1;

    typedef enum logic [2:0] {
        ALU_OUT          = 3'd0,
        LSU_OUT          = 3'd1,
        IMMEDIATE        = 3'd2,
        PC_PLUS_1        = 3'd3,
        VECTOR_TO_SCALAR = 3'd4
    } reg_input_mux_t;

    typedef logic [31:0]            instruction_memory_address_t;
    typedef logic [DEF_WID_W-1:0]   warp_id_t;
    typedef logic [DEF_RA_W-1:0]    reg_addr_t;

endpackage

// File: rtl/multi_warp_scalar_reg_file_scalar_scoreboard.sv
// Per-warp, per-register pending-LSU-write bits with one set port, one clear port
// and two combinational lookup ports. A set and a clear of the same bit in one cycle leaves it set.
module scalar_scoreboard
    import multi_warp_scalar_reg_file_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int NUM_WARPS = 4,
    localparam int RA_W  = $clog2(NUM_REGS),
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_valid,
    input  logic [WID_W-1:0] set_warp,
    input  logic [RA_W-1:0]  set_addr,
    input  logic             clr_valid,
    input  logic [WID_W-1:0] clr_warp,
    input  logic [RA_W-1:0]  clr_addr,
    input  logic [WID_W-1:0] lk_warp,
    input  logic [RA_W-1:0]  lk1_addr,
    input  logic [RA_W-1:0]  lk2_addr,
    output logic             lk1_busy,
    output logic             lk2_busy
);

    logic [NUM_REGS-1:0] r_pending [NUM_WARPS];

    // Set is applied after clear so it takes priority on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_pending[w] <= '0;
            end
        end else begin
            if (clr_valid) begin
                r_pending[clr_warp][clr_addr] <= 1'b0;
            end
            if (set_valid && (set_addr != RA_W'(ZERO_REG))) begin
                r_pending[set_warp][set_addr] <= 1'b1;
            end
        end
    end

    assign lk1_busy = r_pending[lk_warp][lk1_addr];
    assign lk2_busy = r_pending[lk_warp][lk2_addr];

endmodule

// File: rtl/multi_warp_scalar_reg_file.sv
// Scalar register file with NUM_WARPS register sets, registered dual reads, exec and LSU write ports.
// Optional same-cycle write-to-read forwarding is enabled by defining SCALAR_RF_BYPASS_EN.
module multi_warp_scalar_reg_file
    import multi_warp_scalar_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int NUM_REGS   = 32,
    parameter int NUM_WARPS  = 4,
    localparam int RA_W  = $clog2(NUM_REGS),
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rd_req_valid,
    input  logic [WID_W-1:0]                rd_warp_id,
    input  logic [RA_W-1:0]                 rs1_addr,
    input  logic [RA_W-1:0]                 rs2_addr,
    output logic                            rd_rsp_valid,
    output logic [DATA_WIDTH-1:0]           rs1_data,
    output logic [DATA_WIDTH-1:0]           rs2_data,
    output logic                            rs1_busy,
    output logic                            rs2_busy,
    input  logic                            wr_valid,
    input  logic [WID_W-1:0]                wr_warp_id,
    input  logic [RA_W-1:0]                 wr_addr,
    input  reg_input_mux_t                  wr_mux,
    input  logic [DATA_WIDTH-1:0]           alu_out,
    input  logic [DATA_WIDTH-1:0]           lsu_out,
    input  logic [DATA_WIDTH-1:0]           immediate,
    input  logic [DATA_WIDTH-1:0]           vector_to_scalar_data,
    input  instruction_memory_address_t     pc,
    input  logic                            sb_set_valid,
    input  logic [WID_W-1:0]                sb_set_warp,
    input  logic [RA_W-1:0]                 sb_set_addr,
    input  logic                            lsu_wb_valid,
    output logic                            lsu_wb_ready,
    input  logic [WID_W-1:0]                lsu_wb_warp,
    input  logic [RA_W-1:0]                 lsu_wb_addr,
    input  logic [DATA_WIDTH-1:0]           lsu_wb_data,
    output logic [NUM_WARPS*DATA_WIDTH-1:0] warp_execution_mask
);

    localparam int MASK_IDX = NUM_REGS - 1;

    function automatic logic [DATA_WIDTH-1:0] reset_val(input int idx);
        return ((idx == ONES_REG) || (idx == MASK_IDX)) ? '1 : '0;
    endfunction

    logic [DATA_WIDTH-1:0]       r_regs [NUM_WARPS][NUM_REGS];
    logic                        r_vld_p1;
    logic [DATA_WIDTH-1:0]       r_rs1_data_p1;
    logic [DATA_WIDTH-1:0]       r_rs2_data_p1;
    logic                        r_rs1_busy_p1;
    logic                        r_rs2_busy_p1;

    logic [DATA_WIDTH-1:0]       w_wr_data;
    logic                        w_mux_ok;
    logic                        w_exec_we;
    logic                        w_lsu_fire;
    logic                        w_lsu_we;
    logic                        w_sb_busy1;
    logic                        w_sb_busy2;
    logic [DATA_WIDTH-1:0]       w_rs1_data;
    logic [DATA_WIDTH-1:0]       w_rs2_data;
    logic                        w_rs1_busy;
    logic                        w_rs2_busy;
    instruction_memory_address_t w_pc_inc;

    assign w_pc_inc = pc + 32'd1;

    always_comb begin
        w_wr_data = '0;
        w_mux_ok  = 1'b1;
        case (wr_mux)
            ALU_OUT:          w_wr_data = alu_out;
            LSU_OUT:          w_wr_data = lsu_out;
            IMMEDIATE:        w_wr_data = immediate;
            PC_PLUS_1:        w_wr_data = DATA_WIDTH'(w_pc_inc);
            VECTOR_TO_SCALAR: w_wr_data = vector_to_scalar_data;
            default:          w_mux_ok  = 1'b0;
        endcase
    end

    // The execute port owns the write port; the LSU only transfers when it is idle.
    assign lsu_wb_ready = !wr_valid;
    assign w_lsu_fire   = lsu_wb_valid && lsu_wb_ready;
    assign w_exec_we    = wr_valid && w_mux_ok && (wr_addr != RA_W'(ZERO_REG));
    assign w_lsu_we     = w_lsu_fire && (lsu_wb_addr != RA_W'(ZERO_REG));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    r_regs[w][r] <= reset_val(r);
                end
            end
        end else if (w_exec_we) begin
            r_regs[wr_warp_id][wr_addr] <= w_wr_data;
        end else if (w_lsu_we) begin
            r_regs[lsu_wb_warp][lsu_wb_addr] <= lsu_wb_data;
        end
    end

    scalar_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_WARPS (NUM_WARPS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_valid (sb_set_valid),
        .set_warp  (sb_set_warp),
        .set_addr  (sb_set_addr),
        .clr_valid (w_lsu_fire),
        .clr_warp  (lsu_wb_warp),
        .clr_addr  (lsu_wb_addr),
        .lk_warp   (rd_warp_id),
        .lk1_addr  (rs1_addr),
        .lk2_addr  (rs2_addr),
        .lk1_busy  (w_sb_busy1),
        .lk2_busy  (w_sb_busy2)
    );

    always_comb begin
        w_rs1_data = (rs1_addr == RA_W'(ZERO_REG)) ? '0 : r_regs[rd_warp_id][rs1_addr];
        w_rs2_data = (rs2_addr == RA_W'(ZERO_REG)) ? '0 : r_regs[rd_warp_id][rs2_addr];
        w_rs1_busy = w_sb_busy1 && (rs1_addr != RA_W'(ZERO_REG));
        w_rs2_busy = w_sb_busy2 && (rs2_addr != RA_W'(ZERO_REG));
`ifdef SCALAR_RF_BYPASS_EN
        if (w_exec_we && (wr_warp_id == rd_warp_id) && (wr_addr == rs1_addr)) w_rs1_data = w_wr_data;
        if (w_exec_we && (wr_warp_id == rd_warp_id) && (wr_addr == rs2_addr)) w_rs2_data = w_wr_data;
        if (w_lsu_we && (lsu_wb_warp == rd_warp_id) && (lsu_wb_addr == rs1_addr)) begin
            w_rs1_data = lsu_wb_data;
            w_rs1_busy = 1'b0;
        end
        if (w_lsu_we && (lsu_wb_warp == rd_warp_id) && (lsu_wb_addr == rs2_addr)) begin
            w_rs2_data = lsu_wb_data;
            w_rs2_busy = 1'b0;
        end
`endif
    end

    // Stage p1: registered operand response, held between requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1      <= 1'b0;
            r_rs1_data_p1 <= '0;
            r_rs2_data_p1 <= '0;
            r_rs1_busy_p1 <= 1'b0;
            r_rs2_busy_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= rd_req_valid;
            if (rd_req_valid) begin
                r_rs1_data_p1 <= w_rs1_data;
                r_rs2_data_p1 <= w_rs2_data;
                r_rs1_busy_p1 <= w_rs1_busy;
                r_rs2_busy_p1 <= w_rs2_busy;
            end
        end
    end

    assign rd_rsp_valid = r_vld_p1;
    assign rs1_data     = r_rs1_data_p1;
    assign rs2_data     = r_rs2_data_p1;
    assign rs1_busy     = r_rs1_busy_p1;
    assign rs2_busy     = r_rs2_busy_p1;

    for (genvar gw = 0; gw < NUM_WARPS; gw++) begin : g_mask
        assign warp_execution_mask[gw*DATA_WIDTH +: DATA_WIDTH] = r_regs[gw][MASK_IDX];
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (reset || !wr_valid || w_mux_ok)
            else $error("invalid wr_mux %0d on execute write", wr_mux);
    end
`endif

endmodule

// File: tb/tb_multi_warp_scalar_reg_file.sv
// Directed bench for multi_warp_scalar_reg_file (32-bit, 32 regs, 4 warps).
// Expectations for the same-cycle read/write case follow SCALAR_RF_BYPASS_EN.
module tb_multi_warp_scalar_reg_file;
    import multi_warp_scalar_reg_file_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 rd_req_valid;
    logic [1:0]           rd_warp_id;
    logic [4:0]           rs1_addr, rs2_addr;
    logic                 rd_rsp_valid;
    logic [31:0]          rs1_data, rs2_data;
    logic                 rs1_busy, rs2_busy;
    logic                 wr_valid;
    logic [1:0]           wr_warp_id;
    logic [4:0]           wr_addr;
    reg_input_mux_t       wr_mux;
    logic [31:0]          alu_out, lsu_out, immediate, vector_to_scalar_data;
    instruction_memory_address_t pc;
    logic                 sb_set_valid;
    logic [1:0]           sb_set_warp;
    logic [4:0]           sb_set_addr;
    logic                 lsu_wb_valid, lsu_wb_ready;
    logic [1:0]           lsu_wb_warp;
    logic [4:0]           lsu_wb_addr;
    logic [31:0]          lsu_wb_data;
    logic [127:0]         warp_execution_mask;

    int errors = 0;
    int checks = 0;

    multi_warp_scalar_reg_file dut (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_warp_id(rd_warp_id),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_rsp_valid(rd_rsp_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_valid(wr_valid), .wr_warp_id(wr_warp_id), .wr_addr(wr_addr), .wr_mux(wr_mux),
        .alu_out(alu_out), .lsu_out(lsu_out), .immediate(immediate),
        .vector_to_scalar_data(vector_to_scalar_data), .pc(pc),
        .sb_set_valid(sb_set_valid), .sb_set_warp(sb_set_warp), .sb_set_addr(sb_set_addr),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_warp(lsu_wb_warp), .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .warp_execution_mask(warp_execution_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input int w, input int a1, input int a2);
        rd_req_valid = 1'b1;
        rd_warp_id   = 2'(w);
        rs1_addr     = 5'(a1);
        rs2_addr     = 5'(a2);
        tick();
        rd_req_valid = 1'b0;
    endtask

    task automatic do_write(input int w, input int a, input reg_input_mux_t m, input logic [31:0] v);
        wr_valid   = 1'b1;
        wr_warp_id = 2'(w);
        wr_addr    = 5'(a);
        wr_mux     = m;
        alu_out    = v;
        immediate  = v;
        tick();
        wr_valid   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rd_req_valid = 0; rd_warp_id = 0; rs1_addr = 0; rs2_addr = 0;
        wr_valid = 0; wr_warp_id = 0; wr_addr = 0; wr_mux = ALU_OUT;
        alu_out = 0; lsu_out = 0; immediate = 0; vector_to_scalar_data = 0; pc = 0;
        sb_set_valid = 0; sb_set_warp = 0; sb_set_addr = 0;
        lsu_wb_valid = 0; lsu_wb_warp = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
        tick();
        chk("reset_rsp_valid", 128'(rd_rsp_valid), 128'(0));
        chk("reset_rs1_data", 128'(rs1_data), 128'(0));
        chk("reset_rs1_busy", 128'(rs1_busy), 128'(0));
        chk("reset_mask", warp_execution_mask, {128{1'b1}});
        reset = 1'b0;
        tick();

        for (int w = 0; w < 4; w++) begin
            do_read(w, 0, 1);
            chk("reset_r0", 128'(rs1_data), 128'(0));
            chk("reset_r1", 128'(rs2_data), 128'(32'hFFFF_FFFF));
            do_read(w, 5, 31);
            chk("reset_r5", 128'(rs1_data), 128'(0));
            chk("reset_r31", 128'(rs2_data), 128'(32'hFFFF_FFFF));
        end

        // ALU write and warp isolation
        do_write(2, 7, ALU_OUT, 32'h1234);
        do_read(2, 7, 0);
        chk("alu_rsp_valid", 128'(rd_rsp_valid), 128'(1));
        chk("alu_w2r7", 128'(rs1_data), 128'(32'h1234));
        tick();
        chk("hold_rsp_valid", 128'(rd_rsp_valid), 128'(0));
        chk("hold_data", 128'(rs1_data), 128'(32'h1234));
        do_read(1, 7, 0);
        chk("iso_w1r7", 128'(rs1_data), 128'(0));

        // r0 is read-only; PC_PLUS_1 source
        do_write(0, 0, IMMEDIATE, 32'hDEAD);
        pc = 32'h10;
        do_write(0, 3, PC_PLUS_1, 32'h0);
        do_read(0, 0, 3);
        chk("r0_ignored", 128'(rs1_data), 128'(0));
        chk("pc_plus_1", 128'(rs2_data), 128'(32'h11));

        // Scoreboard and LSU handshake
        sb_set_valid = 1; sb_set_warp = 1; sb_set_addr = 9;
        tick();
        sb_set_valid = 0;
        do_read(1, 9, 0);
        chk("sb_busy_set", 128'(rs1_busy), 128'(1));
        chk("sb_r0_busy", 128'(rs2_busy), 128'(0));
        lsu_wb_valid = 1; lsu_wb_warp = 1; lsu_wb_addr = 9; lsu_wb_data = 32'hCAFE;
        wr_valid = 1; wr_warp_id = 0; wr_addr = 10; wr_mux = ALU_OUT; alu_out = 32'h77;
        #1;
        chk("lsu_stall0", 128'(lsu_wb_ready), 128'(0));
        tick();
        chk("lsu_stall1", 128'(lsu_wb_ready), 128'(0));
        tick();
        wr_valid = 0;
        #1;
        chk("lsu_ready", 128'(lsu_wb_ready), 128'(1));
        tick();
        lsu_wb_valid = 0;
        do_read(1, 9, 0);
        chk("lsu_data", 128'(rs1_data), 128'(32'hCAFE));
        chk("lsu_cleared", 128'(rs1_busy), 128'(0));
        do_read(0, 10, 0);
        chk("exec_during_stall", 128'(rs1_data), 128'(32'h77));
        sb_set_valid = 1; sb_set_warp = 1; sb_set_addr = 9;
        lsu_wb_valid = 1; lsu_wb_warp = 1; lsu_wb_addr = 9; lsu_wb_data = 32'hBEEF;
        tick();
        sb_set_valid = 0; lsu_wb_valid = 0;
        do_read(1, 9, 0);
        chk("set_wins", 128'(rs1_busy), 128'(1));
        chk("set_wins_data", 128'(rs1_data), 128'(32'hBEEF));

        // Same-cycle write and read of the same register
        wr_valid = 1; wr_warp_id = 0; wr_addr = 4; wr_mux = ALU_OUT; alu_out = 32'h55;
        rd_req_valid = 1; rd_warp_id = 0; rs1_addr = 4; rs2_addr = 0;
        tick();
        wr_valid = 0; rd_req_valid = 0;
`ifdef SCALAR_RF_BYPASS_EN
        chk("same_cycle", 128'(rs1_data), 128'(32'h55));
`else
        chk("same_cycle", 128'(rs1_data), 128'(0));
`endif
        do_read(0, 4, 0);
        chk("after_write", 128'(rs1_data), 128'(32'h55));

        // Execution mask and reset mid-stall
        do_write(3, 31, ALU_OUT, 32'h0000_000F);
        chk("mask_w3", warp_execution_mask, {32'h0000_000F, {96{1'b1}}});
        sb_set_valid = 1; sb_set_warp = 2; sb_set_addr = 6;
        tick();
        sb_set_valid = 0;
        lsu_wb_valid = 1; lsu_wb_warp = 2; lsu_wb_addr = 6; lsu_wb_data = 32'h1111;
        wr_valid = 1; wr_warp_id = 0; wr_addr = 12; wr_mux = ALU_OUT; alu_out = 32'h99;
        rd_req_valid = 1; rd_warp_id = 2; rs1_addr = 6; rs2_addr = 0;
        tick();
        chk("pre_reset_busy", 128'(rs1_busy), 128'(1));
        reset = 1'b1;
        #1;
        chk("mid_reset_rsp", 128'(rd_rsp_valid), 128'(0));
        chk("mid_reset_busy", 128'(rs1_busy), 128'(0));
        chk("mid_reset_mask", warp_execution_mask, {128{1'b1}});
        lsu_wb_valid = 0; wr_valid = 0; rd_req_valid = 0;
        tick();
        reset = 1'b0;
        tick();
        do_read(2, 6, 0);
        chk("post_reset_sb", 128'(rs1_busy), 128'(0));
        chk("post_reset_lsu_drop", 128'(rs1_data), 128'(0));
        do_read(0, 12, 4);
        chk("post_reset_r12", 128'(rs1_data), 128'(0));
        chk("post_reset_r4", 128'(rs2_data), 128'(0));
        do_read(3, 31, 1);
        chk("post_reset_r31", 128'(rs1_data), 128'(32'hFFFF_FFFF));
        chk("post_reset_r1", 128'(rs2_data), 128'(32'hFFFF_FFFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
